// File: rtl/pong_referee_if.sv
// Signal bundle between the video timing / object logic and the Pong match referee.
// The referee connects through the slave modport; the video side uses master.
interface pong_referee_if #(
    parameter int SCORE_W = 4
);
    logic                      fsync;
    logic signed [11:0]        vpos;
    logic                      active_obj;
    logic                      active_paddle_p1;
    logic                      active_paddle_p2;
    logic        [SCORE_W-1:0] score_p1;
    logic        [SCORE_W-1:0] score_p2;
    logic                      point_p1;
    logic                      point_p2;
    logic                      ball_rst;
    logic                      serve_dir;
    logic                      game_over;
    logic                      winner;

    modport master (
        output fsync, vpos, active_obj, active_paddle_p1, active_paddle_p2,
        input  score_p1, score_p2, point_p1, point_p2, ball_rst, serve_dir, game_over, winner
    );

    modport slave (
        input  fsync, vpos, active_obj, active_paddle_p1, active_paddle_p2,
        output score_p1, score_p2, point_p1, point_p2, ball_rst, serve_dir, game_over, winner
    );
endinterface

// File: rtl/pong_referee.sv
// Pong match referee: per-frame miss detection on both goal rows, scoring, serve/restart pauses.
// Optional macro PONG_REFEREE_WIN_BY_TWO_EN: a win also needs a 2-point lead, ties at WIN_SCORE fall back to deuce.
module pong_referee #(
    parameter int VRES          = 720,
    parameter int PADDLE_H      = 20,
    parameter int SCORE_W       = 4,
    parameter int WIN_SCORE     = 7,
    parameter int MISS_FRAMES   = 2,
    parameter int SERVE_PAUSE   = 60,
    parameter int RESTART_PAUSE = 128
) (
    input  logic           pixel_clk,
    input  logic           rst_n,
    pong_referee_if.slave  bus
);

    localparam logic signed [11:0]  ROW_B     = 12'(VRES - PADDLE_H);
    localparam logic signed [11:0]  ROW_T     = 12'(PADDLE_H - 1);
    localparam logic [3:0]          MISS_LIM  = 4'(MISS_FRAMES);
    localparam logic [7:0]          SERVE_END = 8'(SERVE_PAUSE - 1);
    localparam logic [7:0]          OVER_END  = 8'(RESTART_PAUSE - 1);
    localparam logic [SCORE_W-1:0]  WIN_S     = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        S_SERVE,
        S_PLAY,
        S_POINT,
        S_OVER
    } state_t;

    state_t               state;
    logic [7:0]           frame_cnt;
    logic [3:0]           miss_b;
    logic [3:0]           miss_t;
    logic                 scorer;
    logic [SCORE_W-1:0]   score_p1;
    logic [SCORE_W-1:0]   score_p2;
    logic                 point_p1;
    logic                 point_p2;
    logic                 ball_rst;
    logic                 serve_dir;
    logic                 game_over;
    logic                 winner;

    logic                 seen_b;
    logic                 hit_b;
    logic                 seen_t;
    logic                 hit_t;

    logic                 on_b;
    logic                 on_t;
    logic [3:0]           miss_b_nxt;
    logic [3:0]           miss_t_nxt;
    logic                 miss_b_hit;
    logic                 miss_t_hit;
    logic [SCORE_W-1:0]   new_p1;
    logic [SCORE_W-1:0]   new_p2;
    logic                 match_won;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt == 4'hF) ? cnt : cnt + 4'd1;
    endfunction

`ifdef PONG_REFEREE_WIN_BY_TWO_EN
    function automatic logic wins_by_two(input logic [SCORE_W-1:0] mine,
                                         input logic [SCORE_W-1:0] other);
        return (mine >= WIN_S) &&
               ({1'b0, mine} >= ({1'b0, other} + (SCORE_W+1)'(2)));
    endfunction
`endif

    assign on_b = (bus.vpos == ROW_B) && bus.active_obj;
    assign on_t = (bus.vpos == ROW_T) && bus.active_obj;

    // Row flags collect the whole frame; the fsync cycle itself only clears them
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_b <= 1'b0;
            hit_b  <= 1'b0;
            seen_t <= 1'b0;
            hit_t  <= 1'b0;
        end else if (bus.fsync) begin
            seen_b <= 1'b0;
            hit_b  <= 1'b0;
            seen_t <= 1'b0;
            hit_t  <= 1'b0;
        end else begin
            if (on_b)                         seen_b <= 1'b1;
            if (on_b && bus.active_paddle_p1) hit_b  <= 1'b1;
            if (on_t)                         seen_t <= 1'b1;
            if (on_t && bus.active_paddle_p2) hit_t  <= 1'b1;
        end
    end

    assign miss_b_nxt = (seen_b && !hit_b) ? sat_inc(miss_b) : 4'd0;
    assign miss_t_nxt = (seen_t && !hit_t) ? sat_inc(miss_t) : 4'd0;
    assign miss_b_hit = (miss_b_nxt >= MISS_LIM);
    assign miss_t_hit = (miss_t_nxt >= MISS_LIM);

    // Scores as they will stand after the pending point; scorer 1 means p2
    always_comb begin
        new_p1 = score_p1;
        new_p2 = score_p2;
        if (scorer) new_p2 = score_p2 + 1'b1;
        else        new_p1 = score_p1 + 1'b1;
`ifdef PONG_REFEREE_WIN_BY_TWO_EN
        match_won = scorer ? wins_by_two(new_p2, new_p1) : wins_by_two(new_p1, new_p2);
        if ((new_p1 == WIN_S) && (new_p2 == WIN_S)) begin
            new_p1 = WIN_S - 1'b1;
            new_p2 = WIN_S - 1'b1;
        end
`else
        match_won = scorer ? (new_p2 >= WIN_S) : (new_p1 >= WIN_S);
`endif
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_SERVE;
            frame_cnt <= 8'd0;
            miss_b    <= 4'd0;
            miss_t    <= 4'd0;
            scorer    <= 1'b0;
            score_p1  <= '0;
            score_p2  <= '0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            ball_rst  <= 1'b1;
            serve_dir <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            case (state)
                S_SERVE: begin
                    if (bus.fsync) begin
                        if (frame_cnt == SERVE_END) begin
                            frame_cnt <= 8'd0;
                            ball_rst  <= 1'b0;
                            state     <= S_PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    if (bus.fsync) begin
                        // A bottom miss wins a tie with a simultaneous top miss
                        if (miss_b_hit) begin
                            miss_b   <= 4'd0;
                            miss_t   <= 4'd0;
                            scorer   <= 1'b1;
                            point_p2 <= 1'b1;
                            state    <= S_POINT;
                        end else if (miss_t_hit) begin
                            miss_b   <= 4'd0;
                            miss_t   <= 4'd0;
                            scorer   <= 1'b0;
                            point_p1 <= 1'b1;
                            state    <= S_POINT;
                        end else begin
                            miss_b <= miss_b_nxt;
                            miss_t <= miss_t_nxt;
                        end
                    end
                end
                S_POINT: begin
                    score_p1  <= new_p1;
                    score_p2  <= new_p2;
                    miss_b    <= 4'd0;
                    miss_t    <= 4'd0;
                    frame_cnt <= 8'd0;
                    ball_rst  <= 1'b1;
                    if (match_won) begin
                        game_over <= 1'b1;
                        winner    <= scorer;
                        state     <= S_OVER;
                    end else begin
                        serve_dir <= ~scorer;
                        state     <= S_SERVE;
                    end
                end
                S_OVER: begin
                    if (bus.fsync) begin
                        if (frame_cnt == OVER_END) begin
                            frame_cnt <= 8'd0;
                            score_p1  <= '0;
                            score_p2  <= '0;
                            game_over <= 1'b0;
                            state     <= S_SERVE;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: state <= S_SERVE;
            endcase
        end
    end

    assign bus.score_p1  = score_p1;
    assign bus.score_p2  = score_p2;
    assign bus.point_p1  = point_p1;
    assign bus.point_p2  = point_p2;
    assign bus.ball_rst  = ball_rst;
    assign bus.serve_dir = serve_dir;
    assign bus.game_over = game_over;
    assign bus.winner    = winner;

endmodule

// File: tb/tb_pong_referee.sv
// Scoreboard bench for pong_referee: abstract 6-cycle frames, expected points queued at stimulus time.
module tb_pong_referee;

    localparam int SCORE_W       = 4;
    localparam int WIN_SCORE     = 7;
    localparam int MISS_FRAMES   = 2;
    localparam int SERVE_PAUSE   = 60;
    localparam int RESTART_PAUSE = 128;

    typedef struct packed {
        logic       p2;
        logic [7:0] s1;
        logic [7:0] s2;
        logic       sdir;
        logic       over;
    } exp_t;

    logic pixel_clk = 1'b0;
    logic rst_n     = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    pong_referee_if #(.SCORE_W(SCORE_W)) bus();

    pong_referee #(
        .VRES(720), .PADDLE_H(20), .SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE),
        .MISS_FRAMES(MISS_FRAMES), .SERVE_PAUSE(SERVE_PAUSE), .RESTART_PAUSE(RESTART_PAUSE)
    ) dut (
        .pixel_clk(pixel_clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];
    int   m1 = 0;
    int   m2 = 0;
    bit   msdir = 1'b0;
    int   fs_age = 0;
    bit   pend = 1'b0;
    exp_t cur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One frame: fsync, a bottom-row cycle, a top-row cycle, then idle lines
    task automatic frame(input bit ball_b, input bit pad_b, input bit ball_t, input bit pad_t);
        @(posedge pixel_clk); #1;
        bus.fsync = 1'b1; bus.vpos = 12'sd0;
        bus.active_obj = 1'b0; bus.active_paddle_p1 = 1'b0; bus.active_paddle_p2 = 1'b0;
        @(posedge pixel_clk); #1;
        bus.fsync = 1'b0; bus.vpos = 12'sd700;
        bus.active_obj = ball_b; bus.active_paddle_p1 = pad_b;
        @(posedge pixel_clk); #1;
        bus.vpos = 12'sd19; bus.active_obj = ball_t;
        bus.active_paddle_p1 = 1'b0; bus.active_paddle_p2 = pad_t;
        @(posedge pixel_clk); #1;
        bus.vpos = 12'sd100; bus.active_obj = 1'b0; bus.active_paddle_p2 = 1'b0;
        repeat (2) @(posedge pixel_clk);
        #1;
    endtask

    task automatic wait_serve(input string tag);
        repeat (SERVE_PAUSE - 1) frame(0, 0, 0, 0);
        check({tag, "_ball_rst_hold"}, 32'(bus.ball_rst), 32'd1);
        frame(0, 0, 0, 0);
        check({tag, "_ball_rst_release"}, 32'(bus.ball_rst), 32'd0);
    endtask

    task automatic wait_over(input string tag);
        repeat (RESTART_PAUSE - 1) frame(0, 0, 0, 0);
        check({tag, "_game_over_hold"}, 32'(bus.game_over), 32'd1);
        check({tag, "_winner_hold"}, 32'(bus.winner), 32'd0);
        frame(0, 0, 0, 0);
        check({tag, "_game_over_drop"}, 32'(bus.game_over), 32'd0);
        check({tag, "_score_p1_clr"}, 32'(bus.score_p1), 32'd0);
        check({tag, "_score_p2_clr"}, 32'(bus.score_p2), 32'd0);
        check({tag, "_ball_rst_serve"}, 32'(bus.ball_rst), 32'd1);
        check({tag, "_serve_dir_kept"}, 32'(bus.serve_dir), 32'(msdir));
        m1 = 0;
        m2 = 0;
    endtask

    // Queue the expected outcome, then make the conceding side miss MISS_FRAMES frames
    task automatic play_point(input bit p2_scores, input bit both);
        exp_t e;
        int   n1;
        int   n2;
        bit   over;
        n1 = m1;
        n2 = m2;
        if (p2_scores) n2++; else n1++;
`ifdef PONG_REFEREE_WIN_BY_TWO_EN
        over = p2_scores ? (n2 >= WIN_SCORE && n2 - n1 >= 2) : (n1 >= WIN_SCORE && n1 - n2 >= 2);
        if (n1 == WIN_SCORE && n2 == WIN_SCORE) begin
            n1 = WIN_SCORE - 1;
            n2 = WIN_SCORE - 1;
        end
`else
        over = p2_scores ? (n2 >= WIN_SCORE) : (n1 >= WIN_SCORE);
`endif
        if (!over) msdir = p2_scores ? 1'b0 : 1'b1;
        m1 = n1;
        m2 = n2;
        e.p2 = p2_scores; e.s1 = 8'(n1); e.s2 = 8'(n2); e.sdir = msdir; e.over = over;
        sb_q.push_back(e);
        repeat (MISS_FRAMES) frame(both | p2_scores, 1'b0, both | !p2_scores, 1'b0);
        frame(0, 0, 0, 0);
        if (!over) wait_serve("serve");
    endtask

    always @(negedge pixel_clk) begin
        if (!rst_n) begin
            pend   = 1'b0;
            fs_age = 0;
        end else begin
            if (bus.fsync) fs_age = 0;
            else           fs_age++;
            if (pend) begin
                pend = 1'b0;
                check("score_p1", 32'(bus.score_p1), 32'(cur.s1));
                check("score_p2", 32'(bus.score_p2), 32'(cur.s2));
                check("ball_rst_after_point", 32'(bus.ball_rst), 32'd1);
                check("game_over", 32'(bus.game_over), 32'(cur.over));
                check("serve_dir", 32'(bus.serve_dir), 32'(cur.sdir));
                if (cur.over) check("winner", 32'(bus.winner), 32'(cur.p2));
                check("pulse_width", 32'(bus.point_p1 | bus.point_p2), 32'd0);
            end
            if (bus.point_p1 || bus.point_p2) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_point", 32'd1, 32'd0);
                end else begin
                    cur = sb_q.pop_front();
                    check("point_p1", 32'(bus.point_p1), 32'(!cur.p2));
                    check("point_p2", 32'(bus.point_p2), 32'(cur.p2));
                    check("point_latency", 32'(fs_age), 32'd1);
                    pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fsync = 1'b0;
        bus.vpos = 12'sd0;
        bus.active_obj = 1'b0;
        bus.active_paddle_p1 = 1'b0;
        bus.active_paddle_p2 = 1'b0;
        repeat (3) @(posedge pixel_clk);
        #1;
        check("rst_ball_rst", 32'(bus.ball_rst), 32'd1);
        check("rst_game_over", 32'(bus.game_over), 32'd0);
        check("rst_score_p1", 32'(bus.score_p1), 32'd0);
        check("rst_score_p2", 32'(bus.score_p2), 32'd0);
        check("rst_serve_dir", 32'(bus.serve_dir), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        check("rst_points", 32'(bus.point_p1 | bus.point_p2), 32'd0);
        rst_n = 1'b1;

        wait_serve("serve0");
        check("serve0_score_p1", 32'(bus.score_p1), 32'd0);
        check("serve0_score_p2", 32'(bus.score_p2), 32'd0);

        repeat (10) frame(1, 1, 0, 0);
        frame(0, 0, 0, 0);
        check("covered_miss_b", 32'(dut.miss_b), 32'd0);
        check("covered_miss_t", 32'(dut.miss_t), 32'd0);
        check("covered_ball_rst", 32'(bus.ball_rst), 32'd0);
        check("covered_score_p2", 32'(bus.score_p2), 32'd0);

        play_point(1'b1, 1'b0);
        play_point(1'b1, 1'b1);
        play_point(1'b1, 1'b0);
        repeat (WIN_SCORE) play_point(1'b0, 1'b0);
        wait_over("over0");
        wait_serve("serve1");

        repeat (WIN_SCORE) play_point(1'b0, 1'b0);
        repeat (50) frame(0, 0, 0, 0);
        check("over50_game_over", 32'(bus.game_over), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_game_over", 32'(bus.game_over), 32'd0);
        check("async_rst_score_p1", 32'(bus.score_p1), 32'd0);
        check("async_rst_score_p2", 32'(bus.score_p2), 32'd0);
        check("async_rst_ball_rst", 32'(bus.ball_rst), 32'd1);
        check("async_rst_serve_dir", 32'(bus.serve_dir), 32'd0);
        m1 = 0;
        m2 = 0;
        msdir = 1'b0;
        @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
        wait_serve("serve2");

`ifdef PONG_REFEREE_WIN_BY_TWO_EN
        repeat (WIN_SCORE - 1) begin
            play_point(1'b0, 1'b0);
            play_point(1'b1, 1'b0);
        end
        play_point(1'b1, 1'b0);
        play_point(1'b0, 1'b0);
        check("deuce_score_p1", 32'(bus.score_p1), 32'(WIN_SCORE - 1));
        check("deuce_score_p2", 32'(bus.score_p2), 32'(WIN_SCORE - 1));
`endif

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
